// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: pads frames to the minimum length, appends the
// IEEE 802.3 FCS and drives a gap-free byte burst to the RGMII sender.
module eth_tx_framer #(
  parameter int MIN_BYTES = 60,
  parameter int MAX_BYTES = 1514
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       tx_active,
  output logic [7:0] data,
  output logic       tx_enable,
  output logic       frame_done,
  output logic       frame_error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PAYLOAD = 3'd1,
    PAD     = 3'd2,
    FCS     = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [10:0] MIN_CNT  = 11'(MIN_BYTES);
  localparam logic [10:0] MAX_CNT  = 11'(MAX_BYTES);
  localparam logic [2:0]  FCS_END  = 3'd4;

  state_t      state_r, state_s;
  logic [31:0] crc_r, crc_s;
  logic [10:0] count_r, count_s, count_inc_s;
  logic        bad_r, bad_s;
  logic        drain_r, drain_s;
  logic [2:0]  idx_r, idx_s;
  logic [7:0]  data_r, data_s;
  logic        tx_en_r, tx_en_s;
  logic        done_r, done_s;
  logic        err_r, err_s;
  logic        alive_r;
  logic        ready_s;
  logic        accept_s;

  function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] din);
    logic [31:0] c;
    c = crc ^ {24'h00_0000, din};
    for (int k = 0; k < 8; k++) begin
      if (c[0]) begin
        c = (c >> 1) ^ CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx,
                                          input logic poison);
    logic [31:0] shifted;
    shifted = (~crc) >> {idx, 3'b000};
    return shifted[7:0] ^ {8{poison}};
  endfunction

  // Upstream ready: IDLE waits out the sender's active window, PAYLOAD/DRAIN always take bytes
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      IDLE:           ready_s = ~tx_active;
      PAYLOAD, DRAIN: ready_s = 1'b1;
      default:        ready_s = 1'b0;
    endcase
  end

  // alive_r holds ready low until the first edge after reset release
  assign in_ready = ready_s & alive_r;
  assign accept_s = in_valid & in_ready;

  // Next state, CRC/count bookkeeping and the byte to present after the coming edge
  always_comb begin
    state_s     = state_r;
    crc_s       = crc_r;
    count_s     = count_r;
    bad_s       = bad_r;
    drain_s     = drain_r;
    idx_s       = idx_r;
    data_s      = 8'h00;
    tx_en_s     = 1'b0;
    done_s      = 1'b0;
    err_s       = 1'b0;
    count_inc_s = count_r + 11'd1;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          data_s  = in_data;
          tx_en_s = 1'b1;
          crc_s   = crc_next(crc_r, in_data);
          count_s = 11'd1;
          if (in_last) begin
            state_s = (11'd1 < MIN_CNT) ? PAD : FCS;
          end else begin
            state_s = PAYLOAD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      PAYLOAD: begin
        tx_en_s = 1'b1;
        if (accept_s && (count_r == MAX_CNT)) begin
          // Overflow byte is dropped; the first poisoned FCS byte takes its slot
          data_s  = fcs_byte(crc_r, 2'd0, 1'b1);
          bad_s   = 1'b1;
          drain_s = ~in_last;
          idx_s   = 3'd1;
          state_s = FCS;
        end else if (accept_s) begin
          data_s  = in_data;
          crc_s   = crc_next(crc_r, in_data);
          count_s = count_inc_s;
          if (in_last) begin
            state_s = (count_inc_s < MIN_CNT) ? PAD : FCS;
          end else begin
            state_s = PAYLOAD;
          end
        end else begin
          data_s  = 8'h00;
          crc_s   = crc_next(crc_r, 8'h00);
          count_s = count_inc_s;
          bad_s   = 1'b1;
          drain_s = 1'b1;
          state_s = (count_inc_s < MIN_CNT) ? PAD : FCS;
        end
      end
      PAD: begin
        tx_en_s = 1'b1;
        crc_s   = crc_next(crc_r, 8'h00);
        count_s = count_inc_s;
        if (count_inc_s < MIN_CNT) begin
          state_s = PAD;
        end else begin
          state_s = FCS;
        end
      end
      FCS: begin
        if (idx_r == FCS_END) begin
          done_s  = 1'b1;
          err_s   = bad_r;
          crc_s   = CRC_INIT;
          count_s = 11'd0;
          bad_s   = 1'b0;
          drain_s = 1'b0;
          idx_s   = 3'd0;
          state_s = drain_r ? DRAIN : IDLE;
        end else begin
          data_s  = fcs_byte(crc_r, idx_r[1:0], bad_r);
          tx_en_s = 1'b1;
          idx_s   = idx_r + 3'd1;
        end
      end
      DRAIN: begin
        if (accept_s && in_last) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
        crc_s   = CRC_INIT;
        count_s = 11'd0;
        bad_s   = 1'b0;
        drain_s = 1'b0;
        idx_s   = 3'd0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      crc_r   <= CRC_INIT;
      count_r <= 11'd0;
      bad_r   <= 1'b0;
      drain_r <= 1'b0;
      idx_r   <= 3'd0;
      data_r  <= 8'h00;
      tx_en_r <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      alive_r <= 1'b0;
    end else begin
      state_r <= state_s;
      crc_r   <= crc_s;
      count_r <= count_s;
      bad_r   <= bad_s;
      drain_r <= drain_s;
      idx_r   <= idx_s;
      data_r  <= data_s;
      tx_en_r <= tx_en_s;
      done_r  <= done_s;
      err_r   <= err_s;
      alive_r <= 1'b1;
    end
  end

  assign data        = data_r;
  assign tx_enable   = tx_en_r;
  assign frame_done  = done_r;
  assign frame_error = err_r;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Randomised self-checking bench for eth_tx_framer: a frame-level model builds the
// expected byte burst (payload, pad, FCS) and one process compares it every cycle.
module tb_eth_tx_framer;

  localparam int MINB = 60;
  localparam int MAXB = 1514;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       tx_active;
  logic [7:0] data;
  logic       tx_enable;
  logic       frame_done;
  logic       frame_error;

  logic gap_act  = 1'b0;
  logic hold_act = 1'b0;
  assign tx_active = gap_act | hold_act;

  int checks = 0;
  int failures = 0;
  int frames_sent = 0;
  int frames_done = 0;
  int last_len = 0;
  bit last_err = 1'b0;

  logic [7:0] fr [0:1599];
  logic [7:0] exp_q[$];
  bit         end_q[$];
  bit         err_q[$];

  eth_tx_framer #(.MIN_BYTES(MINB), .MAX_BYTES(MAXB)) dut (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .tx_active(tx_active), .data(data),
    .tx_enable(tx_enable), .frame_done(frame_done), .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] crc_of_str(input string s);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < s.len(); i++) c = crc_byte(c, s[i]);
    return ~c;
  endfunction

  // Frame-level model: which bytes survive, padding, FCS (poisoned when bad)
  task automatic expect_frame(input int n, input int uk);
    logic [7:0]  out_q[$];
    logic [31:0] c;
    bit          bad;
    bad = 1'b0;
    if (uk > 0 && uk < n && uk <= MAXB) begin
      for (int i = 0; i < uk; i++) out_q.push_back(fr[i]);
      out_q.push_back(8'h00);
      bad = 1'b1;
    end else if (n > MAXB) begin
      for (int i = 0; i < MAXB; i++) out_q.push_back(fr[i]);
      bad = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) out_q.push_back(fr[i]);
    end
    while (out_q.size() < MINB) out_q.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (out_q[i]) c = crc_byte(c, out_q[i]);
    c = ~c ^ (bad ? 32'hFFFFFFFF : 32'h0);
    foreach (out_q[i]) begin
      exp_q.push_back(out_q[i]);
      end_q.push_back(1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(c[8*k +: 8]);
      end_q.push_back(k == 3);
    end
    err_q.push_back(bad);
    frames_sent++;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) fr[i] = 8'($urandom);
  endtask

  // Call at a negedge; drops in_valid for one cycle after uk bytes, stops after abort_at bytes
  task automatic send_frame(input int n, input int uk, input int abort_at);
    int i;
    int guard;
    bit ud;
    i = 0; guard = 0; ud = 1'b0;
    while (i < n && i != abort_at && guard < 20000) begin
      if (uk > 0 && i == uk && !ud) begin
        in_valid = 1'b0; in_last = 1'b0; ud = 1'b1;
      end else begin
        in_valid = 1'b1; in_data = fr[i]; in_last = (i == n - 1);
        #1;
        if (in_ready) i++;
      end
      @(negedge clock);
      guard++;
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    if (abort_at < 0) begin
      checks++;
      if (i != n) begin
        failures++;
        $display("FAIL send_frame accepted=%0d want=%0d", i, n);
      end
    end
  endtask

  task automatic wait_frames(input int target);
    int g;
    g = 0;
    while (frames_done < target && g < 8000) begin
      @(negedge clock);
      g++;
    end
    #1;
    checks++;
    if (frames_done < target) begin
      failures++;
      $display("FAIL wait_frames got=%0d want=%0d", frames_done, target);
    end
  endtask

  task automatic check_frame(input string name, input int len, input bit err);
    checks++;
    if (last_len != len || last_err != err) begin
      failures++;
      $display("FAIL %s len/err got=%0d/%0b want=%0d/%0b", name, last_len, last_err, len, err);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  // RGMII sender stand-in: active while sending and for 20 cycles afterwards
  initial begin
    int gap;
    gap = 0;
    forever begin
      @(negedge clock);
      if (tx_enable === 1'b1) gap = 20;
      else if (gap > 0) gap--;
      gap_act = (tx_enable === 1'b1) || (gap > 0);
    end
  end

  // Per-cycle comparison of the burst, frame_done and frame_error against the model
  initial begin
    logic [7:0] b_exp;
    bit         b_end;
    int         burst_len;
    bit         in_burst;
    bit         done_due;
    bit         err_due;
    burst_len = 0; in_burst = 1'b0; done_due = 1'b0; err_due = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n !== 1'b1) begin
        exp_q.delete(); end_q.delete(); err_q.delete();
        burst_len = 0; in_burst = 1'b0; done_due = 1'b0; err_due = 1'b0;
      end else begin
        checks++;
        if (frame_done !== done_due || frame_error !== (done_due & err_due)) begin
          failures++;
          $display("FAIL done/error got=%b/%b want=%b/%b", frame_done, frame_error,
                   done_due, done_due & err_due);
        end
        if (done_due) begin
          last_len = burst_len; last_err = err_due; burst_len = 0; frames_done++;
        end
        done_due = 1'b0;
        if (tx_enable === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL extra_byte got=%02h want=none", data);
          end else begin
            b_exp = exp_q.pop_front();
            b_end = end_q.pop_front();
            if (data !== b_exp) begin
              failures++;
              $display("FAIL data pos=%0d got=%02h want=%02h", burst_len, data, b_exp);
            end
            burst_len++;
            in_burst = !b_end;
            if (b_end) begin
              done_due = 1'b1;
              err_due  = err_q.pop_front();
            end
          end
        end else if (in_burst) begin
          checks++;
          failures++;
          $display("FAIL tx_enable_gap pos=%0d got=0 want=1", burst_len);
          in_burst = 1'b0;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    string s;
    int bl [7] = '{1, 59, 60, 61, 1514, 1515, 1516};
    int bx [7] = '{64, 64, 64, 65, 1518, 1518, 1518};
    bit be [7] = '{0, 0, 0, 0, 0, 1, 1};
    int n;
    int uk;

    reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clock);
    #1;
    check_bit("rst_tx_enable", tx_enable, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_bit("rst_done", frame_done, 1'b0);
    check_bit("rst_error", frame_error, 1'b0);
    checks++;
    if (data !== 8'h00) begin failures++; $display("FAIL rst_data got=%02h want=00", data); end
    reset_n = 1'b1;

    // Pin the model's CRC against published check values
    checks++;
    if (crc_of_str("123456789") !== 32'hCBF43926) begin
      failures++;
      $display("FAIL crc_pin_9 got=%08h want=CBF43926", crc_of_str("123456789"));
    end
    checks++;
    if (crc_of_str("The quick brown fox jumps over the lazy dog") !== 32'h414FA339) begin
      failures++;
      $display("FAIL crc_pin_fox got=%08h want=414FA339",
               crc_of_str("The quick brown fox jumps over the lazy dog"));
    end

    s = "123456789";
    for (int i = 0; i < 9; i++) fr[i] = s[i];
    expect_frame(9, -1);
    @(negedge clock); send_frame(9, -1, -1);
    wait_frames(frames_sent); check_frame("ascii9", 64, 1'b0);

    fill_random(14); expect_frame(14, -1);
    @(negedge clock); send_frame(14, -1, -1);
    wait_frames(frames_sent); check_frame("hdr14", 64, 1'b0);

    fill_random(100); expect_frame(100, 40);
    @(negedge clock); send_frame(100, 40, -1);
    wait_frames(frames_sent); check_frame("underrun40", 64, 1'b1);

    fill_random(1600); expect_frame(1600, -1);
    @(negedge clock); send_frame(1600, -1, -1);
    wait_frames(frames_sent); check_frame("oversize1600", 1518, 1'b1);

    for (int t = 0; t < 7; t++) begin
      fill_random(bl[t]); expect_frame(bl[t], -1);
      @(negedge clock); send_frame(bl[t], -1, -1);
      wait_frames(frames_sent); check_frame("boundary", bx[t], be[t]);
    end

    for (int r = 0; r < 25; r++) begin
      n  = $urandom_range(1, 130);
      uk = (n >= 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, n - 1)) : -1;
      fill_random(n); expect_frame(n, uk);
      @(negedge clock);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      send_frame(n, uk, -1);
    end
    wait_frames(frames_sent);

    // Held-off start: in_ready stays low while the sender is active
    for (int g = 0; g < 200 && tx_active; g++) begin @(negedge clock); #1; end
    fill_random(64); expect_frame(64, -1);
    @(negedge clock);
    hold_act = 1'b1; in_valid = 1'b1; in_data = fr[0]; in_last = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1; check_bit("ready_during_active", in_ready, 1'b0);
      @(negedge clock);
    end
    hold_act = 1'b0;
    #1; check_bit("ready_after_active", in_ready, 1'b1);
    send_frame(64, -1, -1);
    wait_frames(frames_sent); check_frame("held_start", 68, 1'b0);

    // Reset in the middle of a frame; the partial frame is abandoned
    fill_random(100); expect_frame(100, -1);
    frames_sent--;
    @(negedge clock); send_frame(100, -1, 30);
    #2; reset_n = 1'b0; #1;
    check_bit("midrst_tx_enable", tx_enable, 1'b0);
    check_bit("midrst_in_ready", in_ready, 1'b0);
    checks++;
    if (data !== 8'h00) begin failures++; $display("FAIL midrst_data got=%02h want=00", data); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    fill_random(60); expect_frame(60, -1);
    @(negedge clock); send_frame(60, -1, -1);
    wait_frames(frames_sent); check_frame("after_reset", 64, 1'b0);

    repeat (5) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_bytes got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_tx_framer.md
Name: eth_tx_framer

Overview:
- Upstream neighbour of the RGMII transmit stage.
- Accepts an Ethernet frame as a byte stream, starting at the destination MAC, with no preamble or SFD.
- Zero-pads the frame to the minimum length and appends the IEEE 802.3 FCS.
- Drives the continuous one-byte-per-clock data/tx_enable burst that the RGMII sender needs, and holds off new frames while the sender reports the inter-frame gap as active.

Parameters:
MIN_BYTES, 60, minimum frame length before FCS; shorter frames are padded with 8'h00.
MAX_BYTES, 1514, maximum accepted frame length before FCS; longer frames are truncated and poisoned.

Ports:
clock  input  1  byte clock, same as the RGMII sender clock (12.5 MHz at 100 Mbit).
reset_n  input  1  asynchronous active-low reset.
in_data  input  8  frame byte.
in_valid  input  1  in_data valid.
in_last  input  1  marks the final byte of the frame; qualified by in_valid.
in_ready  output  1  byte accepted on a clock edge when in_valid && in_ready.
tx_active  input  1  "active" from the RGMII sender (sending or inter-frame gap).
data  output  8  byte to the RGMII sender.
tx_enable  output  1  high for every byte of the frame, including pad and FCS.
frame_done  output  1  one-cycle pulse after the last FCS byte.
frame_error  output  1  one-cycle pulse with frame_done when the frame was poisoned.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; in_ready=0, data=8'h00, tx_enable=0, frame_done=0, frame_error=0.
  - crc=32'hFFFFFFFF, count=0, bad=0.
  - Reset mid-frame: tx_enable drops immediately; the partial frame is abandoned. The RGMII sender ends the burst, and the receiver discards the frame on bad FCS.
- States: IDLE, PAYLOAD, PAD, FCS, DRAIN.
- IDLE:
  - in_ready = !tx_active.
  - On an in_valid && in_ready edge: register the byte, go to PAYLOAD, set count=1, update crc with the byte.
- Output timing:
  - data and tx_enable are registered; an accepted byte appears on data one cycle after acceptance.
  - tx_enable rises with the first byte and stays high without a gap through the last FCS byte.
- PAYLOAD:
  - in_ready=1. Each accepted byte is output, count++, crc updated.
  - in_last accepted:
    - count < MIN_BYTES → PAD.
    - otherwise → FCS.
  - Underrun (in_valid=0 in PAYLOAD):
    - Output 8'h00 and fold it into crc, count++.
    - Set bad=1, then go to PAD or FCS using the same MIN_BYTES rule.
    - Then go to DRAIN until in_last.
  - Overflow: a byte accepted with count == MAX_BYTES and no in_last is not output; set bad=1, go to FCS, then DRAIN.
- PAD:
  - in_ready=0. Output 8'h00, fold into crc, count++, until count == MIN_BYTES → FCS.
- FCS:
  - Output four bytes of ~crc, least-significant byte first.
  - If bad, each FCS byte is additionally XORed with 8'hFF, which guarantees an FCS mismatch.
  - After the 4th byte:
    - Pulse frame_done (and frame_error if bad).
    - If a drain is owed → DRAIN; otherwise → IDLE.
    - Reload crc, count and bad.
- DRAIN:
  - in_ready=1, tx_enable=0. Discard bytes until in_last is accepted, then → IDLE.
- CRC arithmetic:
  - Reflected polynomial 32'hEDB88320, LSB-first, one byte per clock, computed combinationally over 8 bits.
  - Init 32'hFFFFFFFF; transmitted value is the complement.
  - CRC covers payload and pad only.
- count is 11 bits and never wraps, because MAX_BYTES < 2048.
- Back-to-back frames:
  - No new frame is accepted until tx_active is low.
  - The RGMII sender keeps active high for 8 purge + 12 gap cycles, so frame spacing is enforced externally.
  - An in_valid held during the gap is accepted on the first cycle tx_active=0.
- Simultaneous events:
  - in_last together with the overflow byte: treated as overflow, the byte is dropped and no DRAIN is needed.
  - Underrun on the cycle following in_last: impossible, since the state has already left PAYLOAD.

Test Plan:
1. MIN_BYTES=1; send ASCII "123456789" (31..39), continuous valid → data shows those 9 bytes, then 26 39 F4 CB; tx_enable high for exactly 13 consecutive cycles; frame_done pulses once, frame_error=0.
2. Default params; send 14-byte header with in_last → 14 bytes, 46×00, 4 FCS bytes matching the reference CRC model; tx_enable high for 64 cycles.
3. Send 100 bytes and drop in_valid at byte 40 → 00 output at position 41, pad to 60, FCS equals the model value XOR FFFFFFFF; frame_error pulses; remaining 60 bytes consumed with in_ready=1 and tx_enable=0.
4. Send a 1600-byte frame → exactly 1514 bytes plus 4 poisoned FCS bytes; frame_error=1; bytes 1515–1600 drained; IDLE after in_last.
5. Hold tx_active=1 for 20 cycles with in_valid=1 → in_ready=0 throughout; first byte accepted on the cycle tx_active falls.
6. Assert reset_n=0 at byte 30 of a frame → tx_enable, in_ready, data go low/zero immediately; after release a new 60-byte frame produces the correct FCS.
